// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: dump FSM encodings and
// the default forced-grant wait limit.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  localparam int unsigned STALL_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational owner select for the dmem port: the pipeline wins unless a
// forced dump grant is active; otherwise a pending dump read gets the port.
module dmem_port_mux #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 7
) (
  input  logic               pipe_read,
  input  logic               pipe_write,
  input  logic [NB_ADDR-1:0] pipe_addr,
  input  logic [NB_DATA-1:0] pipe_wdata,
  input  logic               force_grant,
  input  logic               dump_req,
  input  logic [NB_ADDR-1:0] dump_addr,
  output logic               dump_grant,
  output logic               mem_enable,
  output logic               mem_read,
  output logic               mem_write,
  output logic [NB_ADDR-1:0] mem_addr,
  output logic [NB_DATA-1:0] mem_wdata
);

  logic pipe_own;

  always_comb begin
    pipe_own   = (pipe_read | pipe_write) & ~force_grant;
    dump_grant = 1'b0;
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (pipe_own) begin
      mem_enable = 1'b1;
      mem_read   = pipe_read;
      mem_write  = pipe_write;
      mem_addr   = pipe_addr;
      mem_wdata  = pipe_wdata;
    end else if (dump_req) begin
      dump_grant = 1'b1;
      mem_enable = 1'b1;
      mem_read   = 1'b1;
      mem_addr   = dump_addr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the MEM stage (priority) and the debug dump engine.
// Optional DMEM_ARB_STALL_EN forces a dump grant after STALL_LIMIT waits.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_ADDR     = 7,
  parameter int unsigned N_WORDS     = 128,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pipe_read,
  input  logic               i_pipe_write,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  output logic               o_pipe_stall,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic               o_mem_enable,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

  dump_state_t        state, state_next;
  logic [NB_ADDR-1:0] addr_cnt;
  logic [NB_DATA-1:0] data_reg;
  logic               addr_clr, addr_inc, capture;
  logic               dump_grant, force_grant;

  dmem_port_mux #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_port_mux (
    .pipe_read   (i_pipe_read),
    .pipe_write  (i_pipe_write),
    .pipe_addr   (i_pipe_addr),
    .pipe_wdata  (i_pipe_wdata),
    .force_grant (force_grant),
    .dump_req    (state == ST_READ),
    .dump_addr   (addr_cnt),
    .dump_grant  (dump_grant),
    .mem_enable  (o_mem_enable),
    .mem_read    (o_mem_read),
    .mem_write   (o_mem_write),
    .mem_addr    (o_mem_addr),
    .mem_wdata   (o_mem_wdata)
  );

  // dmem drives its read data combinationally back to the MEM stage.
  assign o_pipe_rdata = i_mem_rdata;

`ifdef DMEM_ARB_STALL_EN
  localparam int unsigned WAIT_W = $clog2(STALL_LIMIT + 2);
  logic [WAIT_W-1:0] wait_cnt;

  // Saturates at the limit; any grant or leaving READ restarts the wait.
  always_ff @(posedge i_clk) begin
    if (i_reset || state != ST_READ || dump_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(STALL_LIMIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign force_grant  = (state == ST_READ) && (wait_cnt == WAIT_W'(STALL_LIMIT));
  assign o_pipe_stall = force_grant;
`else
  assign force_grant  = 1'b0;
  assign o_pipe_stall = 1'b0;
`endif

  always_comb begin
    state_next = state;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_next = ST_READ;
          addr_clr   = 1'b1;
        end
      end
      ST_READ: begin
        if (dump_grant) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_dump_ready) begin
          if (addr_cnt == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            addr_inc   = 1'b1;
            state_next = ST_READ;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      data_reg <= '0;
    end else begin
      state <= state_next;
      if (addr_clr) begin
        addr_cnt <= '0;
      end else if (addr_inc) begin
        addr_cnt <= addr_cnt + NB_ADDR'(1);
      end
      if (capture) begin
        data_reg <= i_mem_rdata;
      end
    end
  end

  assign o_dump_valid = (state == ST_HOLD);
  assign o_dump_busy  = (state != ST_IDLE);
  assign o_dump_done  = (state == ST_DONE);
  assign o_dump_data  = data_reg;
  assign o_dump_addr  = addr_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and a dump
// scoreboard; the DMEM_ARB_STALL_EN branch is checked when that macro is set.
module tb_dmem_arbiter;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 7;
  localparam int N_WORDS = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pipe_read = 1'b0, pipe_write = 1'b0;
  logic [NB_ADDR-1:0] pipe_addr = '0;
  logic [NB_DATA-1:0] pipe_wdata = '0;
  logic [NB_DATA-1:0] pipe_rdata;
  logic               pipe_stall;
  logic               dump_start = 1'b0, dump_ready = 1'b0;
  logic               dump_valid, dump_busy, dump_done;
  logic [NB_DATA-1:0] dump_data;
  logic [NB_ADDR-1:0] dump_addr;
  logic               mem_enable, mem_read, mem_write;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_wdata;
  logic [NB_DATA-1:0] mem_rdata = '0;

  logic [NB_DATA-1:0] mem    [N_WORDS];
  logic [NB_DATA-1:0] shadow [N_WORDS];
  logic [NB_ADDR+NB_DATA-1:0] sb_q [$];
  logic [NB_ADDR+NB_DATA-1:0] mon_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_WORDS (N_WORDS),
    .STALL_LIMIT (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pipe_read  (pipe_read),
    .i_pipe_write (pipe_write),
    .i_pipe_addr  (pipe_addr),
    .i_pipe_wdata (pipe_wdata),
    .o_pipe_rdata (pipe_rdata),
    .o_pipe_stall (pipe_stall),
    .i_dump_start (dump_start),
    .i_dump_ready (dump_ready),
    .o_dump_valid (dump_valid),
    .o_dump_data  (dump_data),
    .o_dump_addr  (dump_addr),
    .o_dump_busy  (dump_busy),
    .o_dump_done  (dump_done),
    .o_mem_enable (mem_enable),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // dmem: samples reads and writes on the falling edge of the request cycle.
  always @(negedge clk) begin
    if (mem_enable) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A handshake completes at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && dump_valid && dump_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("dump_unexpected_word", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("dump_addr", dump_addr, mon_e[NB_ADDR+NB_DATA-1:NB_DATA]);
        check_eq("dump_data", dump_data, mon_e[NB_DATA-1:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int a, input logic [NB_DATA-1:0] d);
    pipe_write = 1'b1;
    pipe_addr  = NB_ADDR'(a);
    pipe_wdata = d;
    shadow[a]  = d;
    next_cycle();
    pipe_write = 1'b0;
  endtask

  task automatic load_chk(input string tag, input int a);
    pipe_read = 1'b1;
    pipe_addr = NB_ADDR'(a);
    #7;
    check_eq(tag, pipe_rdata, shadow[a]);
    check_eq("pipe_stall_idle", pipe_stall, 0);
    next_cycle();
    pipe_read = 1'b0;
  endtask

  task automatic start_dump();
    for (int i = 0; i < N_WORDS; i++)
      sb_q.push_back({NB_ADDR'(i), shadow[i]});
    dump_start = 1'b1;
    next_cycle();
    dump_start = 1'b0;
  endtask

  // Returns the cycle index (start pulse cycle = 0) of the done pulse.
  task automatic wait_done(input int first, output int n);
    n = first;
    while (n < first + 2000) begin
      #7;
      if (dump_done) break;
      next_cycle();
      n++;
    end
    if (!dump_done) check_eq("done_timeout", dump_done, 1);
    next_cycle();
  endtask

  task automatic wait_hold_addr(input int a);
    int k;
    for (k = 0; k < 400; k++) begin
      if (dump_valid && dump_addr == NB_ADDR'(a)) break;
      next_cycle();
    end
    if (k == 400) check_eq("hold_addr_timeout", dump_addr, a);
  endtask

  initial begin
    int n;
    int a;
    int first_stall;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", dump_busy, 0);
    check_eq("rst_valid", dump_valid, 0);
    check_eq("rst_done", dump_done, 0);
    check_eq("rst_stall", pipe_stall, 0);
    check_eq("rst_mem_en", mem_enable, 0);
    check_eq("rst_dump_addr", dump_addr, 0);
    check_eq("rst_dump_data", dump_data, 0);
    rst = 1'b0;
    next_cycle();

    // Pipeline store then load, no dump
    store(5, 32'hDEADBEEF);
    load_chk("pipe_load_5", 5);

    // Preload value = addr, full dump with ready high
    for (int i = 0; i < N_WORDS; i++) store(i, NB_DATA'(i));
    dump_ready = 1'b1;
    start_dump();
    wait_done(1, n);
    check_eq("done_cycle", n, 2 * N_WORDS + 1);
    #7;
    check_eq("busy_after_done", dump_busy, 0);
    check_eq("sb_empty_full", sb_q.size(), 0);
    next_cycle();

    // Backpressure on word 3; a start pulse mid-dump must be ignored
    start_dump();
    wait_hold_addr(3);
    dump_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      dump_start = (k == 5);
      #7;
      check_eq("bp_valid", dump_valid, 1);
      check_eq("bp_addr", dump_addr, 3);
      check_eq("bp_data", dump_data, shadow[3]);
      next_cycle();
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    next_cycle();
    next_cycle();
    #7;
    check_eq("bp_next_valid", dump_valid, 1);
    check_eq("bp_next_addr", dump_addr, 4);
    next_cycle();
    wait_done(0, n);
    check_eq("sb_empty_bp", sb_q.size(), 0);

    // Continuous pipeline loads during a dump
    start_dump();
    a = 10;
    first_stall = -1;
    for (int i = 1; i <= 40; i++) begin
      pipe_read = 1'b1;
      pipe_addr = NB_ADDR'(a);
      #7;
`ifdef DMEM_ARB_STALL_EN
      if (pipe_stall) begin
        if (first_stall < 0) begin
          first_stall = i;
          check_eq("first_stall_cycle", first_stall, 9);
        end
      end else begin
        check_eq("traffic_load", pipe_rdata, shadow[a]);
        a = (a + 3) % N_WORDS;
      end
`else
      check_eq("traffic_stall", pipe_stall, 0);
      check_eq("traffic_no_valid", dump_valid, 0);
      check_eq("traffic_busy", dump_busy, 1);
      check_eq("traffic_load", pipe_rdata, shadow[a]);
      a = (a + 3) % N_WORDS;
`endif
      next_cycle();
    end
    pipe_read = 1'b0;
    wait_done(0, n);
    check_eq("sb_empty_traffic", sb_q.size(), 0);

    // Reset while holding word 40, then restart
    start_dump();
    wait_hold_addr(40);
    dump_ready = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    next_cycle();
    rst = 1'b0;
    #7;
    check_eq("abort_busy", dump_busy, 0);
    check_eq("abort_valid", dump_valid, 0);
    check_eq("abort_done", dump_done, 0);
    check_eq("abort_mem_en", mem_enable, 0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      #7;
      check_eq("abort_no_done", dump_done, 0);
      next_cycle();
    end
    dump_ready = 1'b1;
    start_dump();
    next_cycle();
    #7;
    check_eq("restart_valid", dump_valid, 1);
    check_eq("restart_addr", dump_addr, 0);
    next_cycle();
    wait_done(3, n);
    check_eq("restart_done_cycle", n, 2 * N_WORDS + 1);
    check_eq("sb_empty_restart", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
